// File: rtl/branch_pkg.sv
// Shared types and sizing for the branch tag scheduler and its resolve mask.
package branch_pkg;

  localparam int MAX_PREDICT_DEPTH      = 4;
  localparam int MAX_PREDICT_DEPTH_BITS = 3;

  // Tag 0 is the non-speculative table; 1..MAX_PREDICT_DEPTH are checkpoints.
  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_t;

  localparam branch_tag_t MAX_TAG = branch_tag_t'(MAX_PREDICT_DEPTH);

  typedef enum logic [1:0] {
    RUN,
    SHOOT,
    RECOVER,
    MERGE
  } bt_state_e;

endpackage

// File: rtl/branch_resolve_mask.sv
// Per-tag "resolved correct" flags for the outstanding branch checkpoints.
module branch_resolve_mask
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_set,
  input  branch_tag_t i_set_tag,
  input  logic        i_clr_from,
  input  branch_tag_t i_clr_tag,
  input  logic        i_clr_all,
  input  branch_tag_t i_depth,
  output logic        o_all_resolved
);

  logic [MAX_PREDICT_DEPTH:1] r_mask;
  logic                       w_all_resolved;

  // NOTE: the flags are reset like any register; a stale bit would fake a merge.
  always_ff @(posedge clk) begin
    if (!reset || i_clr_all) begin
      r_mask <= '0;
    end else begin
      for (int i = 1; i <= MAX_PREDICT_DEPTH; i++) begin
        // NOTE: non-blocking assignments keep every flag update on the same edge.
        if (i_clr_from && i >= int'(i_clr_tag))
          r_mask[i] <= 1'b0;
        else if (i_set && i == int'(i_set_tag))
          r_mask[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: assign a default before the loop so no latch is inferred.
    w_all_resolved = 1'b1;
    for (int i = 1; i <= MAX_PREDICT_DEPTH; i++) begin
      if (i <= int'(i_depth) && !r_mask[i])
        w_all_resolved = 1'b0;
    end
  end

  assign o_all_resolved = w_all_resolved;

endmodule

// File: rtl/branch_tag_ctrl.sv
// Branch tag allocator and RAT shootdown/merge sequencer.
// Optional BRANCH_TAG_STATS_EN adds saturating allocation/mispredict/stall counters.
module branch_tag_ctrl
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_valid,
  output logic        alloc_ready,
  output branch_tag_t alloc_tag,
  output branch_tag_t cur_tag,
  input  logic        resolve_valid,
  input  branch_tag_t resolve_tag,
  input  logic        resolve_mispredict,
  output logic        branch_shootdown,
  output branch_tag_t shootdown_branch_tag,
  output logic        merge_req,
  output branch_tag_t merge_tag,
  input  logic        merge_ack,
  output logic        flush,
  output logic        bad_resolve
`ifdef BRANCH_TAG_STATS_EN
  ,
  output logic [31:0] stat_allocs,
  output logic [31:0] stat_mispredicts,
  output logic [31:0] stat_stall_cycles
`endif
);

  bt_state_e   r_state, w_next_state;
  branch_tag_t r_depth, w_next_depth;
  logic        r_alloc_ready, r_shoot, r_merge_req, r_bad;
  branch_tag_t r_shoot_tag, r_merge_tag;

  logic w_run, w_alloc_fire, w_tag_ok, w_res_ok;
  logic w_mispredict, w_correct, w_bad, w_all_resolved, w_merge_go, w_merge_done;

  assign w_run        = (r_state == RUN);
  assign w_alloc_fire = alloc_valid && r_alloc_ready;
  assign w_tag_ok     = (resolve_tag != '0) && (resolve_tag <= r_depth);
  assign w_res_ok     = resolve_valid && w_run && w_tag_ok;
  assign w_mispredict = w_res_ok && resolve_mispredict;
  assign w_correct    = w_res_ok && !resolve_mispredict;
  assign w_bad        = resolve_valid && ((w_run && !w_tag_ok) || (r_state == MERGE));
  assign w_merge_done = (r_state == MERGE) && merge_ack;
  // Merge only on a quiet cycle so the mask being judged is the final one.
  assign w_merge_go   = w_run && (r_depth != '0) && w_all_resolved &&
                        !resolve_valid && !w_alloc_fire;

  branch_resolve_mask u_mask (
    .clk            (clk),
    .reset          (reset),
    .i_set          (w_correct),
    .i_set_tag      (resolve_tag),
    .i_clr_from     (w_mispredict),
    .i_clr_tag      (resolve_tag),
    .i_clr_all      (w_merge_done),
    .i_depth        (r_depth),
    .o_all_resolved (w_all_resolved)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_depth = r_depth;
    case (r_state)
      RUN: begin
        if (w_mispredict) begin
          // A branch allocated alongside the mispredict is younger and dies with it.
          w_next_state = SHOOT;
          w_next_depth = resolve_tag - branch_tag_t'(1);
        end else begin
          if (w_alloc_fire) w_next_depth = r_depth + branch_tag_t'(1);
          if (w_merge_go)   w_next_state = MERGE;
        end
      end
      SHOOT:   w_next_state = RECOVER;
      RECOVER: w_next_state = RUN;
      MERGE: begin
        if (merge_ack) begin
          w_next_state = RUN;
          w_next_depth = '0;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= RUN;
      r_depth       <= '0;
      r_alloc_ready <= 1'b1;
      r_shoot       <= 1'b0;
      r_shoot_tag   <= '0;
      r_merge_req   <= 1'b0;
      r_merge_tag   <= '0;
      r_bad         <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_depth       <= w_next_depth;
      r_alloc_ready <= (w_next_state == RUN) && (w_next_depth < MAX_TAG);
      r_shoot       <= w_mispredict;
      r_shoot_tag   <= w_mispredict ? resolve_tag : '0;
      r_merge_req   <= (w_next_state == MERGE);
      r_merge_tag   <= (w_next_state == MERGE) ? w_next_depth : '0;
      if (w_bad) r_bad <= 1'b1;
    end
  end

  assign alloc_ready          = r_alloc_ready;
  assign alloc_tag            = w_alloc_fire ? r_depth + branch_tag_t'(1) : '0;
  assign cur_tag              = r_depth;
  assign branch_shootdown     = r_shoot;
  assign flush                = r_shoot;
  assign shootdown_branch_tag = r_shoot_tag;
  assign merge_req            = r_merge_req;
  assign merge_tag            = r_merge_tag;
  assign bad_resolve          = r_bad;

`ifdef BRANCH_TAG_STATS_EN
  logic [31:0] r_stat_allocs, r_stat_misp, r_stat_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_allocs <= '0;
      r_stat_misp   <= '0;
      r_stat_stall  <= '0;
    end else begin
      r_stat_allocs <= sat_inc(r_stat_allocs, w_alloc_fire);
      r_stat_misp   <= sat_inc(r_stat_misp, w_mispredict);
      r_stat_stall  <= sat_inc(r_stat_stall, alloc_valid && !r_alloc_ready);
    end
  end

  assign stat_allocs       = r_stat_allocs;
  assign stat_mispredicts  = r_stat_misp;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Directed plus random bench for branch_tag_ctrl against a queue-based branch model.
module tb_branch_tag_ctrl;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, alloc_valid, alloc_ready;
  branch_tag_t alloc_tag, cur_tag, resolve_tag, shootdown_branch_tag, merge_tag;
  logic        resolve_valid, resolve_mispredict, branch_shootdown;
  logic        merge_req, merge_ack, flush, bad_resolve;
`ifdef BRANCH_TAG_STATS_EN
  logic [31:0] stat_allocs, stat_mispredicts, stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Model: one entry per outstanding branch (oldest first), value = resolved correct.
  bit          m_q[$];
  int          m_blocked;
  bit          m_merging, m_bad;
  int unsigned m_allocs, m_misp, m_stall;

  branch_tag_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .cur_tag              (cur_tag),
    .resolve_valid        (resolve_valid),
    .resolve_tag          (resolve_tag),
    .resolve_mispredict   (resolve_mispredict),
    .branch_shootdown     (branch_shootdown),
    .shootdown_branch_tag (shootdown_branch_tag),
    .merge_req            (merge_req),
    .merge_tag            (merge_tag),
    .merge_ack            (merge_ack),
    .flush                (flush),
    .bad_resolve          (bad_resolve)
`ifdef BRANCH_TAG_STATS_EN
    ,
    .stat_allocs          (stat_allocs),
    .stat_mispredicts     (stat_mispredicts),
    .stat_stall_cycles    (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_blocked = 0;
    m_merging = 1'b0;
    m_bad     = 1'b0;
    m_allocs  = 0;
    m_misp    = 0;
    m_stall   = 0;
  endtask

  // One clock: drive, check the combinational grant, advance model, check registers.
  task automatic step(input bit av, input bit rv, input int rt, input bit rm,
                      input bit ack, input bit rst);
    int n;
    bit rdy, grant, pulse, all_ok, in_range;
    int ptag;
    alloc_valid        = av;
    resolve_valid      = rv;
    resolve_tag        = rt[2:0];
    resolve_mispredict = rm;
    merge_ack          = ack;
    reset              = rst;
    @(negedge clk);
    n   = m_q.size();
    rdy = !m_merging && m_blocked == 0 && n < MAX_PREDICT_DEPTH;
    check("alloc_tag", alloc_tag, (av && rdy) ? n + 1 : 0);
    pulse = 1'b0;
    ptag  = 0;
    if (!rst) begin
      model_reset();
    end else begin
      grant = av && rdy;
      if (grant) m_allocs++;
      if (av && !rdy) m_stall++;
      if (m_merging) begin
        if (rv) m_bad = 1'b1;
        if (ack) begin
          m_q.delete();
          m_merging = 1'b0;
        end
      end else if (m_blocked > 0) begin
        m_blocked--;
      end else begin
        in_range = rt >= 1 && rt <= n;
        all_ok = 1'b1;
        foreach (m_q[i]) if (!m_q[i]) all_ok = 1'b0;
        if (rv && !in_range) m_bad = 1'b1;
        if (rv && in_range && rm) begin
          while (m_q.size() > rt - 1) void'(m_q.pop_back());
          m_blocked = 2;
          pulse     = 1'b1;
          ptag      = rt;
          m_misp++;
        end else begin
          if (rv && in_range) m_q[rt-1] = 1'b1;
          if (grant) m_q.push_back(1'b0);
        end
        if (!rv && !grant && n > 0 && all_ok) m_merging = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("cur_tag", cur_tag, m_q.size());
    check("alloc_ready", alloc_ready,
          !m_merging && m_blocked == 0 && m_q.size() < MAX_PREDICT_DEPTH);
    check("shootdown", branch_shootdown, pulse);
    check("flush", flush, pulse);
    check("sd_tag", shootdown_branch_tag, ptag);
    check("merge_req", merge_req, m_merging);
    check("merge_tag", merge_tag, m_merging ? m_q.size() : 0);
    check("bad_resolve", bad_resolve, m_bad);
`ifdef BRANCH_TAG_STATS_EN
    check("stat_allocs", stat_allocs, m_allocs);
    check("stat_misp", stat_mispredicts, m_misp);
    check("stat_stall", stat_stall_cycles, m_stall);
`endif
  endtask

  initial begin
    int n;
    int rt;
    reset = 1'b0; alloc_valid = 1'b0; resolve_valid = 1'b0; resolve_tag = '0;
    resolve_mispredict = 1'b0; merge_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", alloc_ready, 1);
    check("rst_cur_tag", cur_tag, 0);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_shoot", branch_shootdown, 0);
    check("rst_merge", merge_req, 0);
    check("rst_bad", bad_resolve, 0);

    // Fill all four checkpoints, then stall.
    repeat (4) step(1, 0, 0, 0, 0, 1);
    check("full_cur_tag", cur_tag, 4);
    check("full_ready", alloc_ready, 0);
    step(1, 0, 0, 0, 0, 1);

    // Drop to depth 3, then mispredict tag 2.
    step(0, 1, 4, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 2, 1, 0, 1);
    check("mp_pulse", branch_shootdown, 1);
    check("mp_tag", shootdown_branch_tag, 2);
    check("mp_ready_shoot", alloc_ready, 0);
    step(0, 0, 0, 0, 0, 1);
    check("mp_pulse_end", branch_shootdown, 0);
    check("mp_ready_recover", alloc_ready, 0);
    step(0, 0, 0, 0, 0, 1);
    check("mp_cur_tag", cur_tag, 1);
    step(1, 0, 0, 0, 0, 1);

    // Depth 2, both resolve correct, merge held until ack.
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("merge_req_on", merge_req, 1);
    check("merge_tag_2", merge_tag, 2);
    repeat (2) step(0, 1, 1, 0, 0, 1);
    check("merge_held", merge_req, 1);
    step(0, 0, 0, 0, 1, 1);
    check("merge_done_tag", cur_tag, 0);
    check("merge_done_ready", alloc_ready, 1);
    step(0, 0, 0, 0, 0, 1);

    // Alloc coinciding with a tag-1 mispredict at depth 1.
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    check("alloc_mp_depth", cur_tag, 0);
    repeat (2) step(0, 0, 0, 0, 0, 1);

    // Out-of-range resolve at depth 1.
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 1);
    check("bad_set", bad_resolve, 1);
    check("bad_depth", cur_tag, 1);
    step(0, 0, 0, 0, 0, 1);
    check("bad_sticky", bad_resolve, 1);

    // Reset in the middle of a merge.
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("pre_rst_merge", merge_req, 1);
    step(0, 0, 0, 0, 0, 0);
    check("rst_merge_req", merge_req, 0);
    check("rst_merge_depth", cur_tag, 0);

    for (int c = 0; c < 3000; c++) begin
      n = m_q.size();
      if ($urandom_range(0, 7) == 0) rt = int'($urandom_range(0, 7));
      else rt = int'($urandom_range(1, (n > 0) ? n : 1));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2, rt,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_tag_ctrl.md
Name: branch_tag_ctrl

Overview:
- Scheduler for the speculative register-alias-table checkpoints.
- Allocates nested branch tags to renamed branches, tracks their resolution, and sequences the RAT shootdown on a mispredict.
- Sequences a merge of the deepest checkpoint into the main table once all outstanding branches have resolved correct.
- Sits between rename/dispatch and the RAT; it is the only driver of the RAT's branch_shootdown and shootdown_branch_tag inputs.

Parameters:
- MAX_PREDICT_DEPTH, 4, number of branch checkpoint tables in the RAT.
- MAX_PREDICT_DEPTH_BITS, 3, tag width. Tag 0 means non-speculative; tags 1..MAX_PREDICT_DEPTH are valid.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- alloc_valid  in  1  rename requests a tag for a new branch.
- alloc_ready  out  1  a tag can be granted this cycle.
- alloc_tag  out  MAX_PREDICT_DEPTH_BITS  tag granted; valid when alloc_valid && alloc_ready.
- cur_tag  out  MAX_PREDICT_DEPTH_BITS  tag rename uses for map/get (equals depth).
- resolve_valid  in  1  a branch has resolved.
- resolve_tag  in  MAX_PREDICT_DEPTH_BITS  tag of the resolving branch.
- resolve_mispredict  in  1  1 = mispredicted, 0 = correct.
- branch_shootdown  out  1  to the RAT; one-cycle pulse.
- shootdown_branch_tag  out  MAX_PREDICT_DEPTH_BITS  to the RAT.
- merge_req  out  1  RAT must copy table merge_tag into the main table.
- merge_tag  out  MAX_PREDICT_DEPTH_BITS  checkpoint to merge.
- merge_ack  in  1  merge has completed.
- flush  out  1  pipeline flush, asserted together with branch_shootdown.
- bad_resolve  out  1  sticky error: a resolve arrived for an unallocated tag.

Behaviour:
- Reset (reset==0 at posedge):
  - depth=0, resolved mask=0, state=RUN.
  - All outputs 0 except alloc_ready=1.
  - Reset mid-SHOOT or mid-MERGE aborts the operation immediately; no pulse completes.
- State RUN:
  - alloc_ready = (depth < MAX_PREDICT_DEPTH). It is purely state-based and never depends on alloc_valid.
  - Accepted alloc: alloc_tag = depth+1; depth increments next cycle.
- Correct resolve, RUN, 1 <= tag <= depth: set resolved[tag].
- Mispredict resolve, RUN, 1 <= tag <= depth:
  - Next cycle enter SHOOT.
  - branch_shootdown=1, flush=1, shootdown_branch_tag=tag, all for exactly one cycle.
  - depth becomes tag-1; resolved bits >= tag are cleared.
  - Then one RECOVER cycle with alloc_ready=0, then RUN.
- Same-cycle events:
  - Alloc accepted in the same cycle as a mispredict: the new branch is younger and discarded; depth = tag-1 regardless.
  - Correct resolve coinciding with alloc: both take effect.
- Resolve with tag 0 or tag > depth: ignored, and bad_resolve is set until reset.
- Merge trigger: in RUN, when depth>0, all resolved[1..depth] are set, and no resolve/alloc is accepted this cycle, go to MERGE.
- State MERGE:
  - merge_req=1, merge_tag=depth, held until merge_ack.
  - alloc_ready=0.
  - Resolves are ignored and flagged via bad_resolve (all branches are already resolved).
  - On merge_ack: depth=0, mask cleared, return to RUN the next cycle.
  - merge_ack outside MERGE is ignored.
- cur_tag always equals the registered depth.
- All outputs are registered except alloc_tag, which is combinational from depth.

Optional Feature:
- BRANCH_TAG_STATS_EN defined:
  - Adds 32-bit saturating counters stat_allocs, stat_mispredicts, stat_stall_cycles, exposed as output ports.
  - stat_stall_cycles counts cycles with alloc_valid && !alloc_ready.
  - All counters clear on reset.
- Undefined: the counters and their ports do not exist.

Decomposition:
- Shared package branch_pkg:
  - branch_tag_t = logic [MAX_PREDICT_DEPTH_BITS-1:0].
  - Enum bt_state_e {RUN, SHOOT, RECOVER, MERGE}.
  - MAX_PREDICT_DEPTH constants, which also move into the package from defines.inc.
- One sub-module, branch_resolve_mask:
  - Holds the per-tag resolved bits.
  - Supports set, clear-from-tag-upward, and clear-all.
  - Outputs all_resolved for a given depth.

Test Plan:
- After reset, 4 allocs back-to-back -> alloc_tag 1,2,3,4; 5th cycle alloc_ready=0, cur_tag=4.
- depth=3, mispredict tag 2 -> next cycle branch_shootdown=1, shootdown_branch_tag=2, flush=1 for 1 cycle; alloc_ready=0 for SHOOT and RECOVER; then cur_tag=1, next alloc_tag=2.
- depth=2, correct resolves for tags 1 and 2 -> merge_req=1, merge_tag=2 held 3 cycles; merge_ack -> cur_tag=0, alloc_ready=1.
- Alloc accepted in the same cycle as mispredict of tag 1 at depth=1 -> depth=0; the granted tag is discarded.
- Resolve tag 3 at depth=1 -> no state change, bad_resolve=1 and sticky.
- reset=0 during MERGE -> merge_req=0, depth=0 next cycle; with BRANCH_TAG_STATS_EN, counters read 0.
